// File: rtl/shift_pipe.sv
`default_nettype none
// ============================================================================
// Module      : shift_pipe
// Description : Two-stage pipelined barrel shifter (SLL / SRA / ROR / ROL)
//               with valid/ready handshakes on both sides and a sideband tag
//               that travels with every operation.
//
//               Stage S1 applies the low half of the shift amount
//               (bits [LO-1:0]). Stage S2 applies the remaining bits
//               [SHAMT_W-1:LO]. Each bit k is one 2^k mux layer.
//
// Ports       : clk       - clock, rising edge
//               rst_n     - synchronous active-low reset
//               in_valid  - request present
//               in_ready  - request can be accepted this cycle
//               in_data   - operand
//               in_shamt  - shift amount, 0..WIDTH-1
//               in_mode   - 00 SLL, 01 SRA, 10 ROR, 11 ROL
//               in_tag    - sideband value, returned unchanged
//               out_valid - result present
//               out_ready - consumer accepts the result
//               out_data  - shifted result
//               out_zero  - out_data == 0
//               out_tag   - tag of the request that produced out_data
//
// Revision    : 1.0 - initial release
// ============================================================================
module shift_pipe #(
    parameter  int WIDTH   = 16,
    parameter  int TAG_W   = 4,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_mode,
    input  logic [TAG_W-1:0]   in_tag,

    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_zero,
    output logic [TAG_W-1:0]   out_tag
);

    // Split point of the shift amount between the two stages.
    localparam int LO    = SHAMT_W / 2;
    localparam int HI_W  = SHAMT_W - LO;

    localparam logic [1:0] c_mode_sll = 2'b00;
    localparam logic [1:0] c_mode_sra = 2'b01;
    localparam logic [1:0] c_mode_ror = 2'b10;

    // ------------------------------------------------------------------
    // One log-shifter layer: shift/rotate d by a fixed amount sh.
    // For SRA the fill comes from msb, the sign of the original operand,
    // so the second stage fills correctly even after the first stage has
    // already moved the sign bit.
    // ------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] shift_layer(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       mode,
        input logic             msb,
        input int               sh
    );
        logic [2*WIDTH-1:0] ext;
        logic [WIDTH-1:0]   r;
        ext = {{WIDTH{msb}}, d} >> sh;
        case (mode)
            c_mode_sll: r = d << sh;
            c_mode_sra: r = ext[WIDTH-1:0];
            c_mode_ror: r = (d >> sh) | (d << (WIDTH - sh));
            default:    r = (d << sh) | (d >> (WIDTH - sh));
        endcase
        return r;
    endfunction

    // Apply the mux layers for amount bits [last-1:first].
    function automatic logic [WIDTH-1:0] apply_layers(
        input logic [WIDTH-1:0]   d,
        input logic [1:0]         mode,
        input logic               msb,
        input logic [SHAMT_W-1:0] amt,
        input int                 first,
        input int                 last
    );
        logic [WIDTH-1:0]   r;
        logic [SHAMT_W-1:0] a;
        r = d;
        a = amt >> first;
        for (int k = first; k < last; k++) begin
            if (a[0]) begin
                r = shift_layer(r, mode, msb, 1 << k);
            end
            a = a >> 1;
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic               s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]   s1_data_q,  s1_data_d;
    logic [HI_W-1:0]    s1_shamt_q, s1_shamt_d;
    logic [1:0]         s1_mode_q,  s1_mode_d;
    logic               s1_msb_q,   s1_msb_d;
    logic [TAG_W-1:0]   s1_tag_q,   s1_tag_d;

    logic               s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0]   s2_data_q,  s2_data_d;
    logic               s2_zero_q,  s2_zero_d;
    logic [TAG_W-1:0]   s2_tag_q,   s2_tag_d;

    logic               w_stall;
    logic [SHAMT_W-1:0] w_s2_amt;

    // Both stages freeze together while the output is blocked.
    assign w_stall  = s2_valid_q && !out_ready;
    assign in_ready = !w_stall;

    // Remaining amount for S2, realigned to its original bit positions.
    assign w_s2_amt = {s1_shamt_q, {LO{1'b0}}};

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_shamt_d = s1_shamt_q;
        s1_mode_d  = s1_mode_q;
        s1_msb_d   = s1_msb_q;
        s1_tag_d   = s1_tag_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_zero_d  = s2_zero_q;
        s2_tag_d   = s2_tag_q;

        if (!w_stall) begin
            s1_valid_d = in_valid;
            s1_data_d  = apply_layers(in_data, in_mode, in_data[WIDTH-1],
                                      in_shamt, 0, LO);
            s1_shamt_d = in_shamt[SHAMT_W-1:LO];
            s1_mode_d  = in_mode;
            s1_msb_d   = in_data[WIDTH-1];
            s1_tag_d   = in_tag;

            s2_valid_d = s1_valid_q;
            s2_data_d  = apply_layers(s1_data_q, s1_mode_q, s1_msb_q,
                                      w_s2_amt, LO, SHAMT_W);
            // Registered alongside the data so it always matches out_data.
            s2_zero_d  = (s2_data_d == '0);
            s2_tag_d   = s1_tag_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_shamt_q <= '0;
            s1_mode_q  <= '0;
            s1_msb_q   <= 1'b0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_zero_q  <= 1'b1;
            s2_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_shamt_q <= s1_shamt_d;
            s1_mode_q  <= s1_mode_d;
            s1_msb_q   <= s1_msb_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_zero_q  <= s2_zero_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_zero  = s2_zero_q;
    assign out_tag   = s2_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_pipe
// Description : Self-checking bench for shift_pipe (WIDTH=16, TAG_W=4).
//               Directed cases, streaming, backpressure, mid-run reset and a
//               random sweep scored against a behavioural reference queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_shamt;
    logic [1:0]  in_mode;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_zero;
    logic [3:0]  out_tag;

    int          n_pass  = 0;
    int          n_total = 0;
    int          n_drained = 0;
    bit          acc_flag = 1'b0;
    logic [19:0] exp_q[$];

    shift_pipe #(.WIDTH(16), .TAG_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    // Reference: plain arithmetic on the whole amount at once.
    function automatic logic [15:0] ref_shift(input logic [15:0] d,
                                              input logic [3:0]  s,
                                              input logic [1:0]  m);
        logic [31:0] w;
        int          sh;
        sh = int'(s);
        case (m)
            2'b00:   begin w = {16'h0, d} << sh;                    return w[15:0];  end
            2'b01:   begin w = {{16{d[15]}}, d};
                           w = $unsigned($signed(w) >>> sh);        return w[15:0];  end
            2'b10:   begin w = {d, d} >> sh;                        return w[15:0];  end
            default: begin w = {d, d} << sh;                        return w[31:16]; end
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    endtask

    // One clock: sample at the falling edge, score handshakes, advance.
    task automatic step();
        logic [19:0] e;
        @(negedge clk);
        check("in_ready_rule", 32'(in_ready), 32'(!(out_valid && !out_ready)));
        acc_flag = rst_n && in_valid && in_ready;
        if (rst_n && out_valid && out_ready) begin
            check("result_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out_data", 32'(out_data), 32'(e[15:0]));
                check("out_tag",  32'(out_tag),  32'(e[19:16]));
                check("out_zero", 32'(out_zero), 32'(e[15:0] == 16'h0));
                n_drained++;
            end
        end
        if (acc_flag) exp_q.push_back({in_tag, ref_shift(in_data, in_shamt, in_mode)});
        @(posedge clk);
        #1;
        if (!rst_n) exp_q.delete();
    endtask

    task automatic present(input logic [1:0] m, input logic [15:0] d,
                           input logic [3:0] s, input logic [3:0] t);
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        in_shamt = s;
        in_tag   = t;
    endtask

    task automatic present_rand(input logic [3:0] t);
        present(2'($urandom_range(0, 3)), 16'($urandom), 4'($urandom_range(0, 15)), t);
    endtask

    // Single request into an empty pipe; checks 2-cycle latency and value.
    task automatic issue_one(input string name, input logic [1:0] m, input logic [15:0] d,
                             input logic [3:0] s, input logic [15:0] exp);
        present(m, d, s, 4'hA);
        out_ready = 1'b1;
        step();
        check({name, "_accept"}, 32'(acc_flag), 32'd1);
        in_valid = 1'b0;
        check({name, "_early"}, 32'(out_valid), 32'd0);
        step();
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_data"},  32'(out_data),  32'(exp));
        check({name, "_zero"},  32'(out_zero),  32'(exp == 16'h0));
        check({name, "_tag"},   32'(out_tag),   32'hA);
        step();
        check({name, "_empty"}, 32'(out_valid), 32'd0);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
        check("drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [19:0] e;
        logic [3:0]  t;
        int          base;
        int          issued;

        // ---------------- reset ----------------
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_shamt = '0; in_mode = '0; in_tag = '0;
        step();
        step();
        rst_n = 1'b1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_tag",   32'(out_tag),   32'd0);
        check("rst_out_zero",  32'(out_zero),  32'd1);
        check("rst_in_ready",  32'(in_ready),  32'd1);

        // ---------------- directed ----------------
        issue_one("ror_8001_1", 2'b10, 16'h8001, 4'd1,  16'hC000);
        issue_one("rol_1234_4", 2'b11, 16'h1234, 4'd4,  16'h2341);
        issue_one("ror_beef_0", 2'b10, 16'hBEEF, 4'd0,  16'hBEEF);
        issue_one("sra_8000_f", 2'b01, 16'h8000, 4'd15, 16'hFFFF);
        issue_one("sra_7fff_f", 2'b01, 16'h7FFF, 4'd15, 16'h0000);
        issue_one("sll_0001_f", 2'b00, 16'h0001, 4'd15, 16'h8000);
        issue_one("sll_8000_1", 2'b00, 16'h8000, 4'd1,  16'h0000);
        issue_one("rol_8001_0", 2'b11, 16'h8001, 4'd0,  16'h8001);

        // ---------------- streaming ----------------
        out_ready = 1'b1;
        base = n_drained;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) present_rand(4'(i));
            else       in_valid = 1'b0;
            step();
            check("stream_valid", 32'(out_valid), 32'(i >= 1 && i <= 8));
        end
        check("stream_count", 32'(n_drained - base), 32'd8);

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        t = 4'd0;
        present_rand(t);
        step();
        check("bp_acc0", 32'(acc_flag), 32'd1);
        t++;
        present_rand(t);
        step();
        check("bp_acc1", 32'(acc_flag), 32'd1);
        t++;
        present_rand(t);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_in_ready",  32'(in_ready),  32'd0);
        check("bp_first_tag", 32'(out_tag),   32'd0);
        repeat (3) begin
            step();
            e = exp_q[0];
            check("bp_no_accept", 32'(acc_flag),  32'd0);
            check("bp_in_ready",  32'(in_ready),  32'd0);
            check("bp_hold_vld",  32'(out_valid), 32'd1);
            check("bp_hold_data", 32'(out_data),  32'(e[15:0]));
            check("bp_hold_tag",  32'(out_tag),   32'(e[19:16]));
        end
        base = n_drained;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (acc_flag) begin
                t++;
                present_rand(t);
            end
        end
        drain();
        check("bp_total", 32'(n_drained - base), 32'(t));

        // ---------------- reset mid-operation ----------------
        out_ready = 1'b0;
        present_rand(4'd1);
        step();
        present_rand(4'd2);
        step();
        check("mid_full", 32'(out_valid), 32'd1);
        present_rand(4'd3);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        in_valid = 1'b0;
        check("mid_out_valid", 32'(out_valid), 32'd0);
        check("mid_out_data",  32'(out_data),  32'd0);
        check("mid_out_tag",   32'(out_tag),   32'd0);
        check("mid_out_zero",  32'(out_zero),  32'd1);
        check("mid_in_ready",  32'(in_ready),  32'd1);
        issue_one("post_rst", 2'b00, 16'h0003, 4'd2, 16'h000C);

        // ---------------- random sweep ----------------
        in_valid = 1'b0;
        base = n_drained;
        issued = 0;
        for (int cyc = 0; cyc < 60000 && (n_drained - base) < 10000; cyc++) begin
            if (!in_valid || acc_flag) begin
                present_rand(4'($urandom));
                in_valid = ($urandom_range(0, 3) != 0) && (issued < 10000);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
            if (acc_flag) issued++;
        end
        check("sweep_count", 32'(n_drained - base), 32'd10000);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
